// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 definitions: exception type encodings, ExcCode values,
// CP0 register numbers and Status/Cause field positions.
package cp0_exception_unit_pkg;

  localparam int EXC_TYPE_BUS = 4;

  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_NULL = 4'd0;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_INT  = 4'd1;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_ADEL = 4'd2;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_ADES = 4'd3;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_SYS  = 4'd4;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_BP   = 4'd5;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_RI   = 4'd6;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_OV   = 4'd7;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_ERET = 4'd8;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;

  // Bit positions inside mem_exc_flags
  localparam int FLAG_ADEL_FETCH = 0;
  localparam int FLAG_RI         = 1;
  localparam int FLAG_OV         = 2;
  localparam int FLAG_SYS        = 3;
  localparam int FLAG_BP         = 4;
  localparam int FLAG_ADEL_DATA  = 5;
  localparam int FLAG_ADES       = 6;
  localparam int FLAG_ERET       = 7;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  localparam int CAUSE_IP_LO = 8;
  localparam int CAUSE_TI    = 30;
  localparam int CAUSE_BD    = 31;

endpackage

// File: rtl/cp0_exception_unit_if.sv
// MEM-stage / MTC0 / MFC0 bundle between the pipeline (master) and CP0 (slave).
interface cp0_exception_unit_if;
  logic [5:0]  hw_int;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delay_slot;
  logic [7:0]  mem_exc_flags;
  logic [31:0] mem_bad_addr;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic [3:0]  exception_type;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;

  modport master (
    output hw_int, mem_valid, mem_pc, mem_in_delay_slot, mem_exc_flags, mem_bad_addr,
    output cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    input  cp0_rdata, exception_type, cp0_epc, cp0_status, cp0_cause
  );

  modport slave (
    input  hw_int, mem_valid, mem_pc, mem_in_delay_slot, mem_exc_flags, mem_bad_addr,
    input  cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    output cp0_rdata, exception_type, cp0_epc, cp0_status, cp0_cause
  );
endinterface

// File: rtl/cp0_exc_arbiter.sv
// Combinational MEM-stage exception picker: one exception per cycle, fixed priority.
module cp0_exc_arbiter
  import cp0_exception_unit_pkg::*;
(
  input  logic [7:0]              exc_flags,
  input  logic                    pend,
  input  logic                    mem_valid,
  output logic [EXC_TYPE_BUS-1:0] exc_type,
  output logic [4:0]              exc_code
);

  always_comb begin
    exc_type = EXC_TYPE_NULL;
    exc_code = EXCCODE_INT;
    // Interrupts are only taken against a real instruction so EPC is meaningful
    if (mem_valid) begin
      if (pend) begin
        exc_type = EXC_TYPE_INT;  exc_code = EXCCODE_INT;
      end else if (exc_flags[FLAG_ADEL_FETCH]) begin
        exc_type = EXC_TYPE_ADEL; exc_code = EXCCODE_ADEL;
      end else if (exc_flags[FLAG_RI]) begin
        exc_type = EXC_TYPE_RI;   exc_code = EXCCODE_RI;
      end else if (exc_flags[FLAG_OV]) begin
        exc_type = EXC_TYPE_OV;   exc_code = EXCCODE_OV;
      end else if (exc_flags[FLAG_SYS]) begin
        exc_type = EXC_TYPE_SYS;  exc_code = EXCCODE_SYS;
      end else if (exc_flags[FLAG_BP]) begin
        exc_type = EXC_TYPE_BP;   exc_code = EXCCODE_BP;
      end else if (exc_flags[FLAG_ADEL_DATA]) begin
        exc_type = EXC_TYPE_ADEL; exc_code = EXCCODE_ADEL;
      end else if (exc_flags[FLAG_ADES]) begin
        exc_type = EXC_TYPE_ADES; exc_code = EXCCODE_ADES;
      end else if (exc_flags[FLAG_ERET]) begin
        exc_type = EXC_TYPE_ERET; exc_code = EXCCODE_INT;
      end
    end
  end

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 register file plus MEM-stage exception commit. Count/Compare timer is
// built only when CP0_COUNT_TIMER_EN is defined.
module cp0_exception_unit
  import cp0_exception_unit_pkg::*;
#(
  parameter logic [31:0] INIT_STATUS = 32'h0040_0000,
  parameter int          COUNT_DIV   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  cp0_exception_unit_if.slave bus
);

  if (COUNT_DIV < 1 || COUNT_DIV > 4) begin : g_bad_count_div
    $error("COUNT_DIV must be in 1..4");
  end

  logic [31:0]             status;
  logic [31:0]             epc;
  logic [31:0]             badvaddr;
  logic                    cause_bd;
  logic [1:0]              cause_ip_sw;
  logic [5:0]              cause_ip_hw;
  logic [4:0]              cause_exccode;
  logic                    timer_int;
  logic [7:0]              cause_ip;
  logic [31:0]             cause;
  logic                    pend;
  logic [EXC_TYPE_BUS-1:0] exc_type;
  logic [4:0]              exc_code;
  logic                    exc_commit;
  logic                    eret_commit;
  logic                    mtc0_commit;
  logic [31:0]             rd_reg;

  assign cause_ip = {cause_ip_hw[5] | timer_int, cause_ip_hw[4:0], cause_ip_sw};
  assign cause    = {cause_bd, timer_int, 14'd0, cause_ip, 1'b0, cause_exccode, 2'b00};
  assign pend     = status[STATUS_IE] & ~status[STATUS_EXL]
                  & (|(cause_ip & status[STATUS_IM_LO +: 8]));

  cp0_exc_arbiter u_arbiter (
    .exc_flags (bus.mem_exc_flags),
    .pend      (pend),
    .mem_valid (bus.mem_valid),
    .exc_type  (exc_type),
    .exc_code  (exc_code)
  );

  assign exc_commit  = (exc_type != EXC_TYPE_NULL) && (exc_type != EXC_TYPE_ERET);
  assign eret_commit = (exc_type == EXC_TYPE_ERET);
  // An MTC0 alongside any exception belongs to a flushed instruction
  assign mtc0_commit = bus.cp0_we && (exc_type == EXC_TYPE_NULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status        <= INIT_STATUS;
      epc           <= 32'd0;
      badvaddr      <= 32'd0;
      cause_bd      <= 1'b0;
      cause_ip_sw   <= 2'b00;
      cause_ip_hw   <= 6'd0;
      cause_exccode <= 5'd0;
    end else begin
      cause_ip_hw <= bus.hw_int;
      if (exc_commit) begin
        status[STATUS_EXL] <= 1'b1;
        cause_exccode      <= exc_code;
        // Nested exceptions keep the original return point
        if (!status[STATUS_EXL]) begin
          epc      <= bus.mem_in_delay_slot ? bus.mem_pc - 32'd4 : bus.mem_pc;
          cause_bd <= bus.mem_in_delay_slot;
        end
        if (exc_type == EXC_TYPE_ADEL)
          badvaddr <= bus.mem_exc_flags[FLAG_ADEL_FETCH] ? bus.mem_pc : bus.mem_bad_addr;
        else if (exc_type == EXC_TYPE_ADES)
          badvaddr <= bus.mem_bad_addr;
      end else if (eret_commit) begin
        status[STATUS_EXL] <= 1'b0;
      end else if (mtc0_commit) begin
        case (bus.cp0_waddr)
          CP0_REG_STATUS: status      <= (status & ~STATUS_WMASK) | (bus.cp0_wdata & STATUS_WMASK);
          CP0_REG_CAUSE:  cause_ip_sw <= bus.cp0_wdata[CAUSE_IP_LO +: 2];
          CP0_REG_EPC:    epc         <= bus.cp0_wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_COUNT_TIMER_EN
  localparam logic [1:0] PRESC_LAST = 2'(COUNT_DIV - 1);

  logic [31:0] count;
  logic [31:0] compare;
  logic [1:0]  presc;
  logic        ti_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 32'd0;
      compare <= 32'd0;
      presc   <= 2'd0;
      ti_q    <= 1'b0;
    end else begin
      if (mtc0_commit && bus.cp0_waddr == CP0_REG_COUNT) begin
        count <= bus.cp0_wdata;
        presc <= 2'd0;
      end else if (presc == PRESC_LAST) begin
        count <= count + 32'd1;
        presc <= 2'd0;
      end else begin
        presc <= presc + 2'd1;
      end
      // A zero Compare disables the timer match
      if (mtc0_commit && bus.cp0_waddr == CP0_REG_COMPARE) begin
        compare <= bus.cp0_wdata;
        ti_q    <= 1'b0;
      end else if (count == compare && compare != 32'd0) begin
        ti_q <= 1'b1;
      end
    end
  end

  assign timer_int = ti_q;
`else
  assign timer_int = 1'b0;
`endif

  function automatic logic reg_writable(input logic [4:0] r);
    case (r)
      CP0_REG_STATUS, CP0_REG_CAUSE, CP0_REG_EPC: return 1'b1;
`ifdef CP0_COUNT_TIMER_EN
      CP0_REG_COUNT, CP0_REG_COMPARE: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    rd_reg = 32'd0;
    case (bus.cp0_raddr)
      CP0_REG_BADVADDR: rd_reg = badvaddr;
`ifdef CP0_COUNT_TIMER_EN
      CP0_REG_COUNT:    rd_reg = count;
      CP0_REG_COMPARE:  rd_reg = compare;
`endif
      CP0_REG_STATUS:   rd_reg = status;
      CP0_REG_CAUSE:    rd_reg = cause;
      CP0_REG_EPC:      rd_reg = epc;
      default:          rd_reg = 32'd0;
    endcase
  end

  assign bus.cp0_rdata = (bus.cp0_we && bus.cp0_waddr == bus.cp0_raddr && reg_writable(bus.cp0_raddr))
                         ? bus.cp0_wdata : rd_reg;
  assign bus.cp0_epc   = (bus.cp0_we && bus.cp0_waddr == CP0_REG_EPC) ? bus.cp0_wdata : epc;
  assign bus.exception_type = exc_type;
  assign bus.cp0_status     = status;
  assign bus.cp0_cause      = cause;

endmodule

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
- Source end of the exception/flush path: the System Control Coprocessor (CP0) register file plus the MEM-stage exception arbiter.
- Collects per-instruction exception flags and hardware interrupts, and picks one exception per cycle.
- Drives `exception_type` and `cp0_epc` to the pipeline controller, which turns them into `flush` and `exc_pc`.
- Updates EPC, Cause, Status and BadVAddr, and serves MFC0 reads and MTC0 writes.

Parameters:
- INIT_STATUS, 32'h0040_0000, Status reset value (BEV=1, IE=0, EXL=0, IM=0).
- COUNT_DIV, 2, core cycles per Count increment; legal range 1..4.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- hw_int  in  6  hardware interrupt lines, level-sensitive, map to Cause.IP[7:2]
- mem_valid  in  1  MEM stage holds a real instruction (0 = bubble)
- mem_pc  in  32  PC of the MEM instruction
- mem_in_delay_slot  in  1  MEM instruction sits in a branch delay slot
- mem_exc_flags  in  8  one-hot-or-more: {ERET, ADES, ADEL_DATA, BP, SYS, OV, RI, ADEL_FETCH}
- mem_bad_addr  in  32  faulting data address for ADEL_DATA/ADES
- cp0_we  in  1  MTC0 commit from MEM
- cp0_waddr  in  5  MTC0 register number
- cp0_wdata  in  32  MTC0 data
- cp0_raddr  in  5  MFC0 register number (EX stage)
- cp0_rdata  out  32  MFC0 data, combinational
- exception_type  out  4  encoded exception, EXC_TYPE_NULL when none
- cp0_epc  out  32  EPC for ERET, MTC0-forwarded
- cp0_status  out  32  current Status
- cp0_cause  out  32  current Cause

Behaviour:
- Reset values:
  - Status = INIT_STATUS; Cause, EPC, BadVAddr, Count, Compare = 0.
  - Outputs are derived from these, so at reset exception_type = NULL and cp0_epc = 0.
- Registers:
  - Implemented: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14).
  - Any other number reads 0; writes to it are ignored.
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[1:0] only (software interrupts).
  - Count, Compare, EPC: full 32 bits.
  - BadVAddr: read-only.
- Interrupt pending:
  - pend = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
  - Cause.IP[7:2] is sampled from hw_int every cycle. IP[7] is hw_int[5] ORed with the timer interrupt (TI) bit.
- Arbitration: combinational, only when mem_valid = 1. Priority order:
  1. INT
  2. ADEL_FETCH
  3. RI
  4. OV
  5. SYS
  6. BP
  7. ADEL_DATA
  8. ADES
  9. ERET
- When mem_valid = 0, exception_type = NULL; interrupts wait for a valid instruction.
- Commit on the clock edge when exception_type is not NULL and not ERET:
  - EXL ← 1.
  - Cause.ExcCode ← INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12.
  - If EXL was 0: EPC ← mem_in_delay_slot ? mem_pc − 4 : mem_pc, and Cause.BD ← mem_in_delay_slot.
  - If EXL was already 1: EPC and BD are left unchanged.
  - BadVAddr ← mem_pc for ADEL_FETCH; ← mem_bad_addr for ADEL_DATA/ADES.
- ERET commit: EXL ← 0; nothing else changes.
- MTC0 and exception in the same cycle: the exception wins and the MTC0 write is dropped (it is being flushed).
- cp0_epc forwarding: if cp0_we and cp0_waddr = 14 in the same cycle, cp0_epc = cp0_wdata; otherwise the EPC register.
- cp0_rdata forwarding: MTC0 data is forwarded when the addresses match.
- Timer:
  - Count increments every COUNT_DIV cycles via a prescaler that resets to 0.
  - A Count write reloads Count and clears the prescaler.
  - When Count == Compare and Compare != 0, TI (Cause[30]) sets on the next edge.
  - A Compare write clears TI.
  - Count wraps 0xFFFF_FFFF → 0 silently.
- Asynchronous reset mid-operation returns every register, including the prescaler, to its reset value immediately.

Optional Feature:
- Macro: CP0_COUNT_TIMER_EN.
- Defined: Count/Compare/TI and the prescaler behave as above.
- Undefined:
  - No prescaler or timer logic is built.
  - Count and Compare read 0 and ignore writes.
  - Cause[30] = 0, and IP[7] = hw_int[5] only.

Decomposition:
- Shared package (alongside the existing bus/exception headers) holds:
  - EXC_TYPE_* encodings: NULL=0, INT, ADEL, ADES, SYS, BP, RI, OV, ERET.
  - EXC_TYPE_BUS width 4.
  - ExcCode constants.
  - CP0 register numbers.
  - Status/Cause bit positions.
- Sub-module cp0_exc_arbiter: purely combinational; takes flags, pend and mem_valid; returns exception_type and ExcCode. Top level holds all state.

Test Plan:
- Reset: deassert rst_n → Status=0x0040_0000, exception_type=NULL, cp0_rdata(12)=0x0040_0000.
- SYS in delay slot: mem_pc=0xBFC0_0104, in_delay_slot=1, flags=SYS → type=SYS; next cycle EPC=0xBFC0_0100, Cause.BD=1, ExcCode=8, EXL=1.
- Priority: mem_exc_flags = RI|OV|ADES → type=RI, BadVAddr unchanged. Then ADES alone with bad_addr=0x8000_0003 → BadVAddr=0x8000_0003, ExcCode=5.
- Interrupt masking:
  - Status IE=1, IM[2]=1, hw_int[0]=1, mem_valid=1 → type=INT.
  - Same with EXL=1 → type=NULL.
  - mem_valid=0 → NULL.
- ERET forwarding: MTC0 EPC=0x1234_5678 in the same cycle as flags=ERET → cp0_epc=0x1234_5678, type=ERET; next cycle EXL=0.
- Timer (CP0_COUNT_TIMER_EN defined):
  - Compare=10, Count=0, COUNT_DIV=2 → TI sets about 20 cycles later.
  - IE=1, IM[7]=1 → INT.
  - Writing Compare clears TI.
